regfile_read_port: RTL
======================

# regfile_read_port

- Pipelined read-port sequencer for the bit-cell register array; it is the reading end of the shared tri-state bitlines.
- Accepts register read requests over a valid/ready handshake and drives one one-hot word read-enable per cycle into the array.
- Samples the resulting bitline bus and returns the word over a second valid/ready handshake.
- One instance serves each array read port; the CPU decode stage instantiates two.

## Interface
- WIDTH, 16, data word width (bitline count)
- REGS, 16, number of registers (word lines)
- ADDR_W, 4, register address width; REGS <= 2^ADDR_W
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- req_valid  input  1  read request present
- req_ready  output  1  port can accept request this cycle
- req_addr  input  ADDR_W  register to read
- ReadEnable  output  REGS  one-hot word read enables to array cells
- Bitline  input  WIDTH  shared bitline bus driven by enabled cells
- wr_en  input  1  array write strobe, same cycle as cell WriteEnable
- wr_addr  input  ADDR_W  register being written
- wr_data  input  WIDTH  data being written
- rsp_valid  output  1  rsp_data holds a completed read
- rsp_ready  input  1  consumer takes response this cycle
- rsp_data  output  WIDTH  read result

## Operation
- Two stages: A (issue: a_valid, a_addr) and B (response: rsp_valid, rsp_data).
- b_free = !rsp_valid | rsp_ready; req_ready = !a_valid | b_free (combinational).
- Request accept: at an edge with req_valid & req_ready, a_addr <= req_addr and a_valid <= 1. Otherwise, if A advances, a_valid <= 0.
- ReadEnable = a_valid ? onehot(a_addr) : 0, decoded from registered state only.
  - ReadEnable is never driven for address 0 or for addresses >= REGS.
  - At most one bit is ever high.
- A advances at an edge with a_valid & b_free:
  - rsp_data <= captured word; rsp_valid <= 1.
  - Captured word is 0 for address 0 or out-of-range, else Bitline.
- Response consumed (rsp_valid & rsp_ready) with no A advance: rsp_valid <= 0; rsp_data holds its value.
- Stall (a_valid & !b_free): a_addr and ReadEnable hold; rsp_data holds; no new request is accepted.
- Register 0 is hardwired zero: all reads of address 0 return 0 with no array access.
- Simultaneous accept and advance in one edge is legal; this gives full throughput of one read per cycle.

## Timing
- Reset values (async, immediate): a_valid=0, rsp_valid=0, rsp_data=0, ReadEnable=0. req_ready=1 while rst is high.
- Latency:
  - Request accepted at edge t0.
  - ReadEnable asserted during cycle t0..t1.
  - Bitline sampled at t1; rsp_valid=1 after t1.
  - Two edges from accept to valid response.
- Throughput: one response per cycle while rsp_ready is held high.
- Reset asserted mid-operation drops in-flight requests silently. No response is produced for them after release.
- rsp_data is stable while rsp_valid & !rsp_ready.

## Configuration
- Macro: REGFILE_READ_BYPASS_EN.
- Defined (write bypass on):
  - Capture edge with wr_en=1, wr_addr==a_addr, and a_addr in 1..REGS-1: rsp_data <= wr_data instead of Bitline.
  - This returns the value being written in the same cycle.
- Undefined: wr_en, wr_addr and wr_data are ignored. A same-cycle write returns the old cell value sampled from Bitline.

## Test plan
- Reset then single read: cell 5 holds 0xBEEF; req addr 5 accepted at t0 -> ReadEnable=0x0020 during t0..t1; rsp_valid=1, rsp_data=0xBEEF after t1.
- Back-to-back reads of addresses 1, 2, 3 with rsp_ready=1 -> responses 1, 2, 3 on consecutive cycles; req_ready stays 1.
- Backpressure:
  - Stimulus: rsp_ready=0 with two requests issued.
  - Second request: held in A with ReadEnable steady; req_ready=0.
  - First response: rsp_data unchanged.
  - After rsp_ready=1 for two cycles: both responses delivered in order.
- Address 0 and address 16 (REGS=16, ADDR_W=5) -> ReadEnable=0, rsp_data=0x0000.
- Same-cycle write: wr_en=1, wr_addr=7, wr_data=0x1234 at capture edge of a read of 7; cell held 0x0F0F -> 0x1234 with REGFILE_READ_BYPASS_EN, 0x0F0F without.
- rst pulsed while A and B are both valid -> ReadEnable=0 and rsp_valid=0 immediately; no response after release.

Source files
------------

// File: rtl/regfile_read_port.sv
// regfile_read_port: two-stage read-port sequencer for the bit-cell register array.
// Stage A issues a one-hot word read enable onto the shared bitlines. Stage B
// captures the bitline word and holds it until the consumer takes it.
// Register 0 reads as zero, and so do addresses >= REGS. Neither drives a read enable.
// Optional feature macro: REGFILE_READ_BYPASS_EN. When defined, a write to the
// register being captured in the same cycle returns the new data (wr_data).
module regfile_read_port #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned REGS   = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic [REGS-1:0]   ReadEnable,
  input  logic [WIDTH-1:0]  Bitline,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  rsp_data
);

  localparam int unsigned CMP_W = ADDR_W + 1;

  // Word-line decode. Bit 0 and out-of-range addresses never assert.
  function automatic logic [REGS-1:0] f_onehot(input logic [ADDR_W-1:0] addr);
    logic [REGS-1:0] v;
    v = '0;
    for (int unsigned i = 1; i < REGS; i++) begin
      if ({1'b0, addr} == CMP_W'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  logic              r_a_valid;
  logic [ADDR_W-1:0] r_a_addr;
  logic [REGS-1:0]   r_read_enable;
  logic              r_rsp_valid;
  logic [WIDTH-1:0]  r_rsp_data;

  logic              w_b_free;
  logic              w_accept;
  logic              w_advance;
  logic              w_a_hit;
  logic [WIDTH-1:0]  w_capture;

  assign w_b_free  = !r_rsp_valid || rsp_ready;
  assign req_ready = !r_a_valid || w_b_free;
  assign w_accept  = req_valid && req_ready;
  assign w_advance = r_a_valid && w_b_free;
  assign w_a_hit   = |f_onehot(r_a_addr);

  assign ReadEnable = r_read_enable;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_rsp_data;

`ifndef REGFILE_READ_BYPASS_EN
  logic w_unused_wr;
  assign w_unused_wr = ^{wr_en, wr_addr, wr_data};
`endif

  // Word captured into stage B: zero for register 0 or out-of-range, else the bitlines.
  always_comb begin
    w_capture = '0;
    if (w_a_hit) begin
      w_capture = Bitline;
`ifdef REGFILE_READ_BYPASS_EN
      if (wr_en && (wr_addr == r_a_addr)) w_capture = wr_data;
`endif
    end
  end

  // Stage A: accept a request and register its decoded read enable; clear it once it advances.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_valid     <= 1'b0;
      r_a_addr      <= '0;
      r_read_enable <= '0;
    end else if (w_accept) begin
      r_a_valid     <= 1'b1;
      r_a_addr      <= req_addr;
      r_read_enable <= f_onehot(req_addr);
    end else if (w_advance) begin
      r_a_valid     <= 1'b0;
      r_read_enable <= '0;
    end
  end

  // Stage B: load the captured word on advance; drop valid when consumed, keep data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else if (w_advance) begin
      r_rsp_valid <= 1'b1;
      r_rsp_data  <= w_capture;
    end else if (r_rsp_valid && rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

endmodule
